// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit words with valid/ready at both ends.
// Each stage keeps its own valid bit so bubbles collapse under back-pressure; also flush and occupancy.
module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             din,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int               OCC_W    = $clog2(DEPTH + 1);
    localparam logic [DEPTH-1:0] ALL_ONES = '1;

    if (DEPTH < 1) begin : g_depth_check
        $error("dff_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [OCC_W-1:0] r_occ;

    logic [DEPTH-1:0] w_acc;
    logic [DEPTH-1:0] w_in_v;
    logic [WIDTH-1:0] w_in_d [DEPTH];
    logic             w_in_xfer;
    logic             w_out_xfer;

    function automatic logic [OCC_W-1:0] f_occ_next(input logic [OCC_W-1:0] occ,
                                                    input logic inc,
                                                    input logic dec);
        return occ + OCC_W'(inc) - OCC_W'(dec);
    endfunction

    // Stage i can advance when dout_ready is high or any stage from i downstream is empty;
    // computed flat from r_v so there is no bit-to-bit combinational chain on one vector.
    always_comb begin
        w_acc  = '0;
        w_in_v = '0;
        w_in_d = '{default: '0};
        for (int i = 0; i < DEPTH; i++) begin
            w_acc[i] = dout_ready | ~&(r_v | ~(ALL_ONES << i));
        end
        w_in_v[0] = din_valid;
        w_in_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            w_in_v[i] = r_v[i-1];
            w_in_d[i] = r_d[i-1];
        end
    end

    assign din_ready  = w_acc[0] & ~flush & ~rst;
    assign dout_valid = r_v[DEPTH-1] & ~flush & ~rst;
    assign dout       = r_d[DEPTH-1];
    assign occupancy  = r_occ;
    assign w_in_xfer  = din_valid & din_ready;
    assign w_out_xfer = dout_valid & dout_ready;

    // Stage registers: data only moves when a valid word enters, so empty slots keep stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= RESET_VAL;
            end
        end else if (flush) begin
            r_v   <= '0;
            r_occ <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_acc[i]) begin
                    r_v[i] <= w_in_v[i];
                    if (w_in_v[i]) begin
                        r_d[i] <= w_in_d[i];
                    end
                end
            end
            r_occ <= f_occ_next(r_occ, w_in_xfer, w_out_xfer);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: a DEPTH=4/WIDTH=8 instance with a FIFO scoreboard, plus a DEPTH=1/WIDTH=1 instance.
module tb_dff_pipe;
    logic       clk = 1'b0;
    logic       rst, flush, din_valid, dout_ready;
    logic [7:0] din;
    logic       din_ready, dout_valid;
    logic [7:0] dout;
    logic [2:0] occupancy;

    logic b_rst, b_din, b_valid, b_rdy, b_flush;
    logic b_din_ready, b_dout, b_dout_valid;
    logic b_occ;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    logic [7:0] sb[$];
    logic [7:0] sb_exp;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .flush(flush), .occupancy(occupancy)
    );

    dff_pipe #(.WIDTH(1), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(b_rst), .din(b_din), .din_valid(b_valid), .din_ready(b_din_ready),
        .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_rdy),
        .flush(b_flush), .occupancy(b_occ)
    );

    // Scoreboard: sample mid-cycle, record the transfers the next rising edge will perform.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (occupancy !== 3'(sb.size())) begin
                bad++;
                $display("FAIL sb_occupancy got=%0d exp=%0d", occupancy, sb.size());
            end
            if (rst || flush) begin
                sb.delete();
            end else begin
                if (dout_valid === 1'b1 && dout_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected_out got=%h exp=none", dout);
                    end else begin
                        sb_exp = sb.pop_front();
                        if (dout !== sb_exp) begin
                            bad++;
                            $display("FAIL sb_order got=%h exp=%h", dout, sb_exp);
                        end
                    end
                end
                if (din_valid && din_ready === 1'b1) sb.push_back(din);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; din = 8'hAA; din_valid = 1'b1; dout_ready = 1'b1;
        b_rst = 1'b1; b_flush = 1'b0; b_din = 1'b1; b_valid = 1'b1; b_rdy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            mon_en = 1'b1;
            total++; if (dout !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h exp=00", dout); end
            total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_dout_valid got=%b exp=0", dout_valid); end
            total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL rst_din_ready got=%b exp=0", din_ready); end
            total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
            total++; if (b_dout !== 1'b0 || b_occ !== 1'b0) begin bad++; $display("FAIL rst_d1 got=%b/%b exp=0/0", b_dout, b_occ); end
        end
        rst = 1'b0; b_rst = 1'b0; din_valid = 1'b0; b_valid = 1'b0;
        #1;
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL post_rst_din_ready got=%b exp=1", din_ready); end
        for (int c = 0; c < 6; c++) begin
            tick();
            total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL post_rst_no_aa got=%b exp=0", dout_valid); end
        end
    endtask

    task automatic test_stream();
        dout_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            din = 8'(k + 1); din_valid = 1'b1;
            #1;
            total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL stream_din_ready k=%0d got=%b exp=1", k, din_ready); end
            tick();
            total++; if (dout_valid !== (k >= 3)) begin bad++; $display("FAIL stream_latency k=%0d got=%b exp=%b", k, dout_valid, (k >= 3)); end
            if (k >= 3) begin
                total++; if (dout !== 8'(k - 2)) begin bad++; $display("FAIL stream_dout k=%0d got=%h exp=%h", k, dout, 8'(k - 2)); end
            end
            total++; if (occupancy !== 3'((k < 3) ? k + 1 : 4)) begin bad++; $display("FAIL stream_occ k=%0d got=%0d", k, occupancy); end
        end
        din_valid = 1'b0;
        repeat (5) tick();
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL stream_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] vals [5];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        dout_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            din = vals[k]; din_valid = 1'b1;
            #1;
            total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL bp_accept k=%0d got=%b exp=1", k, din_ready); end
            tick();
        end
        din = vals[4];
        #1;
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", din_ready); end
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL bp_full_occ got=%0d exp=4", occupancy); end
        total++; if (dout !== 8'h11 || dout_valid !== 1'b1) begin bad++; $display("FAIL bp_full_dout got=%h/%b exp=11/1", dout, dout_valid); end
        dout_ready = 1'b1;
        #1;
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL bp_passthru_ready got=%b exp=1", din_ready); end
        tick();
        dout_ready = 1'b0; din_valid = 1'b0;
        #1;
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL bp_swap_occ got=%0d exp=4", occupancy); end
        total++; if (dout !== 8'h22) begin bad++; $display("FAIL bp_swap_dout got=%h exp=22", dout); end
        dout_ready = 1'b1;
        repeat (5) tick();
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL bp_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_bubbles();
        dout_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            din = 8'hA0 + 8'(k); din_valid = (k % 2 == 0);
            tick();
        end
        din_valid = 1'b0;
        #1;
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL bub_occ got=%0d exp=3", occupancy); end
        total++; if (dout_valid !== 1'b1 || dout !== 8'hA0) begin bad++; $display("FAIL bub_head got=%h/%b exp=a0/1", dout, dout_valid); end
        dout_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            total++; if (dout_valid !== 1'b1 || dout !== 8'hA0 + 8'(2 * j)) begin bad++; $display("FAIL bub_drain j=%0d got=%h/%b exp=%h/1", j, dout, dout_valid, 8'hA0 + 8'(2 * j)); end
            tick();
        end
        total++; if (dout_valid !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL bub_empty got=%b/%0d exp=0/0", dout_valid, occupancy); end
    endtask

    task automatic test_flush();
        dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din = 8'hC1 + 8'(k); din_valid = 1'b1;
            tick();
        end
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL fl_pre_occ got=%0d exp=3", occupancy); end
        flush = 1'b1; din = 8'hC4; din_valid = 1'b1;
        #1;
        total++; if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin bad++; $display("FAIL fl_gate got=%b/%b exp=0/0", din_ready, dout_valid); end
        tick();
        flush = 1'b0; din_valid = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL fl_occ got=%0d exp=0", occupancy); end
        dout_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL fl_ghost c=%0d got=%b exp=0", c, dout_valid); end
        end
    endtask

    task automatic test_mid_reset();
        dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din = 8'h70 + 8'(k); din_valid = 1'b1;
            tick();
        end
        rst = 1'b1; din_valid = 1'b0;
        tick();
        rst = 1'b0; dout_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++; if (dout_valid !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL mrst_ghost c=%0d got=%b/%0d exp=0/0", c, dout_valid, occupancy); end
        end
    endtask

    task automatic test_depth1();
        logic bit_v;
        b_rdy = 1'b1;
        total++; if (b_occ !== 1'b0) begin bad++; $display("FAIL d1_occ0 got=%b exp=0", b_occ); end
        for (int k = 0; k < 10; k++) begin
            bit_v = (k % 2 == 1);
            b_din = bit_v; b_valid = 1'b1;
            #1;
            total++; if (b_din_ready !== 1'b1) begin bad++; $display("FAIL d1_ready k=%0d got=%b exp=1", k, b_din_ready); end
            tick();
            total++; if (b_dout !== bit_v || b_dout_valid !== 1'b1 || b_occ !== 1'b1) begin
                bad++; $display("FAIL d1_delay k=%0d got=%b/%b/%b exp=%b/1/1", k, b_dout, b_dout_valid, b_occ, bit_v);
            end
        end
        b_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubbles();
        test_flush();
        test_mid_reset();
        test_depth1();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
